fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch front end for the RISC-V core. It produces the instruction stream that the decode/controller stage consumes. It holds the PC, issues word reads to instruction memory over a valid/ready request and in-order response interface, and buffers the returned instructions in a small FIFO. It presents the buffered instructions to decode with a valid/ready handshake and pre-extracted op/funct3/funct7b5 fields, and it flushes and refetches on a redirect from the branch/jump resolution logic.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries and maximum in-flight requests (power of 2, >= 2)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response data valid, in request order, no backpressure
imem_rsp_data  input  32  fetched instruction word
redirect_valid  input  1  taken branch/jump/jalr, one-cycle pulse
redirect_pc  input  32  new fetch target
instr_valid  output  1  instr/instr_pc valid to decode
instr_ready  input  1  decode accepts instruction
instr  output  32  instruction word at FIFO head
instr_pc  output  32  address of instr
op  output  7  instr[6:0]
funct3  output  3  instr[14:12]
funct7b5  output  1  instr[30]
misaligned_err  output  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (reset=0, asynchronous): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, misaligned_err=0.
- imem_req_valid=1 whenever (fifo_count + outstanding) < FIFO_DEPTH and out of reset. imem_req_addr=fetch_pc. A request fires on valid&ready; on fire, fetch_pc <= fetch_pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0) and outstanding increments.
- imem_req_valid/addr hold stable until fire, unless a redirect occurs.
- Response: each imem_rsp_valid decrements outstanding. If drop>0, the response is discarded and drop decrements. Otherwise {data, pc} is written to the FIFO tail. Each outstanding entry's pc is tracked in a pc queue of FIFO_DEPTH entries.
- Latency: response in cycle N -> instr_valid=1 in cycle N+1 at the earliest (registered FIFO, no bypass). With zero-wait memory, the first instruction after reset is visible on cycle 3 after reset release.
- Decode handshake: pop on instr_valid&instr_ready. instr, instr_pc and the field outputs are held stable while instr_valid=1 and instr_ready=0. op/funct3/funct7b5 are combinational slices of instr.
- Full: no request is issued when fifo_count+outstanding=FIFO_DEPTH. The FIFO never overflows because reservation guarantees space.
- Same-cycle pop and write on a full FIFO is legal; the count is unchanged.
- Redirect (redirect_valid=1, cycle N):
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - FIFO cleared.
  - drop <= outstanding_next: all in-flight requests, including one firing in cycle N and excluding a response arriving in cycle N, which is itself discarded.
  - A pop in cycle N completes normally.
  - The first request to the new pc is issued in cycle N+1, if reservation allows.
  - misaligned_err=1 in cycle N+1 if redirect_pc[1:0]!=0.
- Back-to-back redirects: the latest redirect wins. drop accumulates, and no stale response ever reaches the FIFO.
- No redirect is accepted during reset. Reset mid-operation discards all in-flight state; any response arriving after reset release with outstanding=0 is ignored.
- Counter widths: outstanding and drop are sized to hold FIFO_DEPTH. A response with outstanding=0 is ignored, and sim asserts.

Test Plan:
1. Zero-wait memory returning mem[a]=a^32'hA5A5_0000, instr_ready=1 -> instr_pc sequence 0,4,8,12 with matching data, one instruction per cycle after fill.
2. instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests issued, then imem_req_valid=0. instr, instr_pc and op stay stable. On release, order is preserved with no duplicates.
3. Redirect to 0x100 while 2 requests are in flight with latency 3 -> both stale responses dropped, next instr_pc=0x100, no instruction from 0x8/0xC seen.
4. Redirect with redirect_pc=0x203 -> fetch from 0x200, misaligned_err high exactly one cycle.
5. RESET_PC=0xFFFF_FFF8 -> instr_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
6. Assert reset low mid-stream with 2 outstanding -> outputs return to reset values immediately. After release, fetch restarts at RESET_PC and late responses are ignored.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
//   Holds the fetch PC, issues word reads to instruction memory, buffers the
//   in-order responses in a small FIFO and presents them to decode together
//   with pre-sliced op/funct3/funct7b5 fields. A redirect flushes the buffer,
//   marks every in-flight request as stale and restarts at the new target.
// Ports:
//   clk, reset                      clock (rising edge), async active-low reset
//   imem_req_valid/ready/addr       fetch request channel (word aligned)
//   imem_rsp_valid/data             in-order response channel, no backpressure
//   redirect_valid/pc               taken branch/jump target (one-cycle pulse)
//   instr_valid/ready, instr,
//   instr_pc, op, funct3, funct7b5  instruction channel to decode
//   misaligned_err                  pulse the cycle after a misaligned redirect
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        misaligned_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t        fifo_q [FIFO_DEPTH];
  logic [31:0]   pcq_q  [FIFO_DEPTH];   // addresses of in-flight requests
  logic [PW-1:0] rd_ptr, wr_ptr, pcq_rd, pcq_wr;
  logic [CW-1:0] count, outstanding, drop, outstanding_nx;
  logic [31:0]   fetch_pc;
  logic          run;
  logic          req_fire, rsp_ok, rsp_keep, pop;
  entry_t        head;

  // Every issued request reserves a FIFO slot, so the buffer cannot overflow.
  assign imem_req_valid = run && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding (e.g. left over from before reset)
  // is ignored. Stale responses, and one arriving with a redirect, are dropped.
  assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
  assign rsp_keep = rsp_ok && (drop == '0) && !redirect_valid;

  assign outstanding_nx = outstanding + CW'(req_fire) - CW'(rsp_ok);

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign head        = fifo_q[rd_ptr];
  assign instr       = instr_valid ? head.data : '0;
  assign instr_pc    = instr_valid ? head.pc   : '0;
  assign op          = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7b5    = instr[30];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run            <= 1'b0;
      fetch_pc       <= RESET_PC;
      outstanding    <= '0;
      drop           <= '0;
      count          <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      pcq_rd         <= '0;
      pcq_wr         <= '0;
      misaligned_err <= 1'b0;
    end else begin
      run            <= 1'b1;
      misaligned_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      outstanding    <= outstanding_nx;
      // The pc queue tracks every in-flight request, stale or not, so it
      // stays aligned with the response stream across redirects.
      if (req_fire) pcq_wr <= pcq_wr + PW'(1);
      if (rsp_ok)   pcq_rd <= pcq_rd + PW'(1);
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[31:2], 2'b00};
        // Everything still in flight after this cycle belongs to the old path.
        drop     <= outstanding_nx;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire)                 fetch_pc <= fetch_pc + 32'd4;
        if (rsp_ok && drop != '0)     drop     <= drop - CW'(1);
        if (rsp_keep)                 wr_ptr   <= wr_ptr + PW'(1);
        if (pop)                      rd_ptr   <= rd_ptr + PW'(1);
        count <= count + CW'(rsp_keep) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: outputs are gated by instr_valid.
  always_ff @(posedge clk) begin
    if (req_fire) pcq_q[pcq_wr] <= fetch_pc;
    if (rsp_keep) fifo_q[wr_ptr] <= '{pc: pcq_q[pcq_rd], data: imem_rsp_data};
  end

  a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
                                   imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit. A memory model
// answers requests in order with a programmable latency; a scoreboard knows
// the instruction stream must be pc, pc+4, ... from the last reset/redirect
// target, with data mem(pc) = pc ^ 32'hA5A5_0000.
module tb_fetch_unit;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

  logic        clk = 1'b0, reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, misaligned_err;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .op(op),
    .funct3(funct3), .funct7b5(funct7b5), .misaligned_err(misaligned_err)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];

  int checks = 0, failures = 0, cyc = 0, last_due = 0;
  int lat = 1, rdy_pct = 100, irdy_pct = 100;
  int fires = 0, pops = 0, first_pop_cyc = 0, last_pop_cyc = 0;
  logic [31:0] exp_req_pc = RPC, exp_instr_pc = RPC, last_pop_pc = '0, first_pop_pc = '0;
  logic mis_exp = 1'b0, last_mis = 1'b0, last_ivalid = 1'b0, last_rvalid = 1'b0;
  logic hold_prev = 1'b0, stall_prev = 1'b0;
  logic [31:0] hold_addr = '0, st_instr = '0, st_pc = '0;
  logic [6:0]  st_op = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic reset_model();
    exp_req_pc = RPC; exp_instr_pc = RPC; mis_exp = 1'b0;
    hold_prev = 1'b0; stall_prev = 1'b0; fires = 0; pops = 0; last_due = 0;
  endtask

  // Sampled at the negedge: decides what the coming posedge will do.
  task automatic observe();
    mreq_t m;
    logic [31:0] w;
    last_mis = misaligned_err; last_ivalid = instr_valid; last_rvalid = imem_req_valid;
    checks++;
    if (misaligned_err !== mis_exp) begin
      failures++;
      $display("FAIL misaligned_err cyc=%0d got=%b want=%b", cyc, misaligned_err, mis_exp);
    end
    if (hold_prev) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== hold_addr) begin
        failures++;
        $display("FAIL req_hold cyc=%0d got valid=%b addr=%h want valid=1 addr=%h",
                 cyc, imem_req_valid, imem_req_addr, hold_addr);
      end
    end
    if (stall_prev) begin
      checks++;
      if (instr !== st_instr || instr_pc !== st_pc || op !== st_op) begin
        failures++;
        $display("FAIL stall_hold cyc=%0d got %h/%h/%h want %h/%h/%h",
                 cyc, instr, instr_pc, op, st_instr, st_pc, st_op);
      end
    end
    if (imem_req_valid === 1'b1 && imem_req_ready) begin
      checks++;
      if (imem_req_addr !== exp_req_pc) begin
        failures++;
        $display("FAIL req_addr cyc=%0d got=%h want=%h", cyc, imem_req_addr, exp_req_pc);
      end
      m.addr = imem_req_addr;
      m.due  = (cyc + lat > last_due) ? cyc + lat : last_due + 1;
      last_due = m.due;
      mq.push_back(m);
      exp_req_pc += 32'd4;
      fires++;
    end
    if (instr_valid === 1'b1 && instr_ready) begin
      w = mem_word(exp_instr_pc);
      checks++;
      if (instr_pc !== exp_instr_pc || instr !== w || op !== w[6:0] ||
          funct3 !== w[14:12] || funct7b5 !== w[30]) begin
        failures++;
        $display("FAIL pop cyc=%0d got pc=%h instr=%h op=%h f3=%h f7b5=%b want pc=%h instr=%h",
                 cyc, instr_pc, instr, op, funct3, funct7b5, exp_instr_pc, w);
      end
      if (pops == 0) begin first_pop_cyc = cyc; first_pop_pc = instr_pc; end
      last_pop_cyc = cyc; last_pop_pc = instr_pc;
      exp_instr_pc += 32'd4;
      pops++;
    end
    hold_prev  = reset && imem_req_valid && !imem_req_ready && !redirect_valid;
    hold_addr  = imem_req_addr;
    stall_prev = reset && instr_valid && !instr_ready && !redirect_valid;
    st_instr = instr; st_pc = instr_pc; st_op = op;
    mis_exp = reset && redirect_valid && (redirect_pc[1:0] != 2'b00);
    if (redirect_valid) begin
      exp_req_pc   = {redirect_pc[31:2], 2'b00};
      exp_instr_pc = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic drive();
    imem_req_ready = ($urandom_range(0, 99) < rdy_pct);
    instr_ready    = ($urandom_range(0, 99) < irdy_pct);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic tick();
    @(negedge clk); observe();
    @(posedge clk); cyc++; #1; drive();
  endtask

  task automatic do_reset();
    reset = 1'b0; hold_prev = 1'b0; stall_prev = 1'b0; mis_exp = 1'b0;
    repeat (4) tick();
    mq.delete(); imem_rsp_valid = 1'b0;
    reset_model();
    reset = 1'b1;
  endtask

  task automatic wait_pops(input int target, input int budget, input string name);
    int n = 0;
    while (pops < target && n < budget) begin tick(); n++; end
    checks++;
    if (pops < target) begin
      failures++;
      $display("FAIL %s_timeout got pops=%0d want>=%0d", name, pops, target);
    end
  endtask

  task automatic wait_inflight(input int budget);
    int n = 0;
    while (mq.size() < 2 && n < budget) begin tick(); n++; end
    checks++;
    if (mq.size() < 2) begin
      failures++;
      $display("FAIL inflight_timeout got=%0d want>=2", mq.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({imem_req_valid, instr_valid, instr, instr_pc, misaligned_err} !== '0) begin
      failures++;
      $display("FAIL reset_values got rv=%b iv=%b instr=%h pc=%h mis=%b want all zero",
               imem_req_valid, instr_valid, instr, instr_pc, misaligned_err);
    end
    lat = 1; rdy_pct = 100; irdy_pct = 100;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    reset_model();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (last_ivalid !== (k == 3)) begin
        failures++;
        $display("FAIL first_latency cycle=%0d got=%b want=%b", k, last_ivalid, (k == 3));
      end
    end
  endtask

  // Stream from RESET_PC through the 32-bit wrap, one per cycle once full.
  task automatic test_stream_wrap();
    wait_pops(6, 40, "stream");
    checks++;
    if (last_pop_pc !== 32'h0000_000C || last_pop_cyc - first_pop_cyc != 5) begin
      failures++;
      $display("FAIL stream_wrap got last_pc=%h span=%0d want last_pc=0000000c span=5",
               last_pop_pc, last_pop_cyc - first_pop_cyc);
    end
  endtask

  task automatic test_stall();
    irdy_pct = 0; rdy_pct = 100; lat = 1;
    do_reset();
    instr_ready = 1'b0;
    repeat (12) tick();
    checks++;
    if (fires != DEPTH || last_rvalid !== 1'b0 || last_ivalid !== 1'b1) begin
      failures++;
      $display("FAIL stall_reservation got fires=%0d rv=%b iv=%b want fires=%0d rv=0 iv=1",
               fires, last_rvalid, last_ivalid, DEPTH);
    end
    irdy_pct = 100;
    wait_pops(DEPTH + 4, 60, "stall_drain");
  endtask

  task automatic redirect_and_check(input logic [31:0] tgt, input string name);
    int p;
    redirect_valid = 1'b1; redirect_pc = tgt;
    tick();
    p = pops;
    wait_pops(p + 1, 60, name);
    checks++;
    if (last_pop_pc !== {tgt[31:2], 2'b00}) begin
      failures++;
      $display("FAIL %s_target got=%h want=%h", name, last_pop_pc, {tgt[31:2], 2'b00});
    end
  endtask

  task automatic test_redirect_drop();
    lat = 3; rdy_pct = 100; irdy_pct = 100;
    wait_inflight(40);
    redirect_and_check(32'h0000_0100, "redirect");
  endtask

  task automatic test_misaligned();
    lat = 2;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
    tick();
    tick();
    checks++;
    if (last_mis !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_pulse got=%b want=1", last_mis);
    end
    tick();
    checks++;
    if (last_mis !== 1'b0) begin
      failures++;
      $display("FAIL misaligned_width got=%b want=0", last_mis);
    end
    checks++;
    if (exp_req_pc[31:8] !== 24'h000002) begin
      failures++;
      $display("FAIL misaligned_fetch got=%h want=000002xx", exp_req_pc);
    end
    wait_pops(pops + 1, 40, "misaligned");
    checks++;
    if (first_pop_pc === 32'hFFFF_FFFF || last_pop_pc[31:8] !== 24'h000002) begin
      failures++;
      $display("FAIL misaligned_target got=%h want=000002xx", last_pop_pc);
    end
  endtask

  task automatic test_back_to_back();
    lat = 3; rdy_pct = 100; irdy_pct = 100;
    wait_inflight(40);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    tick();
    redirect_and_check(32'h0000_0400, "back_to_back");
  endtask

  task automatic test_reset_mid();
    lat = 3; rdy_pct = 100; irdy_pct = 100;
    wait_inflight(40);
    reset = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, instr_valid, instr, instr_pc, misaligned_err} !== '0) begin
      failures++;
      $display("FAIL reset_mid_values got rv=%b iv=%b instr=%h pc=%h mis=%b want all zero",
               imem_req_valid, instr_valid, instr, instr_pc, misaligned_err);
    end
    do_reset();
    wait_pops(4, 60, "reset_restart");
    checks++;
    if (first_pop_pc !== RPC) begin
      failures++;
      $display("FAIL reset_restart_pc got=%h want=%h", first_pop_pc, RPC);
    end
  endtask

  task automatic test_random();
    int p0;
    rdy_pct = 70; irdy_pct = 60;
    p0 = pops;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) lat = $urandom_range(1, 4);
      if ($urandom_range(0, 99) < 4) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'h0000_FFFF;
      end
      tick();
    end
    checks++;
    if (pops - p0 < 50) begin
      failures++;
      $display("FAIL random_progress got pops=%0d want>=50", pops - p0);
    end
  endtask

  initial begin
    test_reset();
    test_stream_wrap();
    test_stall();
    test_redirect_drop();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
